// File: rtl/tc_pl_cap_gain_dac_arb_if.sv
// ---------------------------------------------------------------------------
// tc_pl_cap_gain_dac_arb_if
//
// Purpose: bundles the requester side (per-channel gain-set sequencers) and
// the DAC driver side of the gain-DAC arbiter into one interface.
//
// Signals:
//   req_en     CHN_NUM        per-requester level request
//   req_value  CHN_NUM*DAC_W  requester i's command on [i*DAC_W +: DAC_W]
//   req_cmpt   CHN_NUM        one-cycle completion pulse to the granted requester
//   dac_value  DAC_W          command word presented to the DAC driver
//   dac_en     1              driver start level
//   dac_cmpt   1              driver done pulse
//   busy       1              arbiter not idle
//   grant_id   ID_W           current or most recent grant index
//   dac_err    1              sticky watchdog flag
//
// Modports:
//   master  requesters + driver (drive req_*, dac_cmpt)
//   slave   the arbiter itself
// ---------------------------------------------------------------------------
interface tc_pl_cap_gain_dac_arb_if #(
  parameter int CHN_NUM = 4,
  parameter int DAC_W   = 24,
  parameter int ID_W    = 2
);
  logic [CHN_NUM-1:0]       req_en;
  logic [CHN_NUM*DAC_W-1:0] req_value;
  logic [CHN_NUM-1:0]       req_cmpt;
  logic [DAC_W-1:0]         dac_value;
  logic                     dac_en;
  logic                     dac_cmpt;
  logic                     busy;
  logic [ID_W-1:0]          grant_id;
  logic                     dac_err;

  modport master (
    output req_en, req_value, dac_cmpt,
    input  req_cmpt, dac_value, dac_en, busy, grant_id, dac_err
  );

  modport slave (
    input  req_en, req_value, dac_cmpt,
    output req_cmpt, dac_value, dac_en, busy, grant_id, dac_err
  );
endinterface

// File: rtl/tc_pl_cap_gain_dac_arb.sv
// ---------------------------------------------------------------------------
// tc_pl_cap_gain_dac_arb
//
// Purpose: round-robin arbiter sharing the single gain-DAC serial driver
// between CHN_NUM gain-set channel sequencers. One command word at a time is
// latched and forwarded over dac_en/dac_value/dac_cmpt; the granted requester
// gets a one-cycle req_cmpt pulse when the driver finishes, and the arbiter
// then waits for that requester to drop req_en before granting again.
//
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   tc_pl_cap_gain_dac_arb_if.slave (requester + driver handshakes)
//
// Optional feature (macro DAC_ARB_TIMEOUT_EN):
//   defined     -> a watchdog abandons a transfer after TIMEOUT_CYC cycles in
//                  S_WAIT without dac_cmpt, sets sticky dac_err and moves on.
//   not defined -> S_WAIT waits indefinitely, dac_err is tied low.
// ---------------------------------------------------------------------------
module tc_pl_cap_gain_dac_arb #(
  parameter int CHN_NUM     = 4,
  parameter int DAC_W       = 24,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  tc_pl_cap_gain_dac_arb_if.slave  bus
);

  // Elaboration-time sanity on the parameter set.
  if ((2 ** ID_W) < CHN_NUM || CHN_NUM < 2 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("tc_pl_cap_gain_dac_arb: illegal CHN_NUM/ID_W/TIMEOUT_CYC combination");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_REL  = 2'd2
  } state_t;

  state_t             state, state_d;
  logic               dac_en_q, dac_en_d;
  logic [DAC_W-1:0]   dac_value_q, dac_value_d;
  logic [CHN_NUM-1:0] req_cmpt_q, req_cmpt_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;

  // Winner selection and helpers derived from the current grant.
  logic [2*CHN_NUM-1:0] req_dbl;
  logic [CHN_NUM-1:0]   req_rot;
  logic [ID_W:0]        scan_idx;
  logic [ID_W-1:0]      winner;
  logic                 winner_vld;
  logic [DAC_W-1:0]     win_value;
  logic [CHN_NUM-1:0]   grant_onehot;
  logic                 grant_req;
  logic [ID_W-1:0]      next_ptr;

`ifdef DAC_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_hit;
  logic            dac_err_q, dac_err_d;

  assign to_hit = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
`endif

  // Rotating the doubled request vector right by rr_ptr puts channel
  // (rr_ptr + k) mod CHN_NUM at bit k, so the lowest set bit is the winner.
  assign req_dbl = {bus.req_en, bus.req_en} >> rr_ptr_q;
  assign req_rot = req_dbl[CHN_NUM-1:0];

  always_comb begin
    winner     = '0;
    winner_vld = 1'b0;
    scan_idx   = '0;
    // Scan from the far end so the nearest pending channel is assigned last.
    for (int k = CHN_NUM - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        scan_idx = {1'b0, rr_ptr_q} + (ID_W + 1)'(k);
        if (scan_idx >= (ID_W + 1)'(CHN_NUM)) begin
          scan_idx = scan_idx - (ID_W + 1)'(CHN_NUM);
        end
        winner     = scan_idx[ID_W-1:0];
        winner_vld = 1'b1;
      end
    end
  end

  always_comb begin
    win_value    = '0;
    grant_onehot = '0;
    grant_req    = 1'b0;
    for (int k = 0; k < CHN_NUM; k++) begin
      if (winner == ID_W'(k)) begin
        win_value = bus.req_value[k*DAC_W +: DAC_W];
      end
      if (grant_q == ID_W'(k)) begin
        grant_onehot[k] = 1'b1;
        grant_req       = bus.req_en[k];
      end
    end
  end

  assign next_ptr = (grant_q == ID_W'(CHN_NUM - 1)) ? '0 : grant_q + 1'b1;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      state       <= S_IDLE;
      dac_en_q    <= 1'b0;
      dac_value_q <= '0;
      req_cmpt_q  <= '0;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
`ifdef DAC_ARB_TIMEOUT_EN
      to_cnt_q    <= '0;
      dac_err_q   <= 1'b0;
`endif
    end else begin
      state       <= state_d;
      dac_en_q    <= dac_en_d;
      dac_value_q <= dac_value_d;
      req_cmpt_q  <= req_cmpt_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef DAC_ARB_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      dac_err_q   <= dac_err_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every target gets a default before the case so no path leaves a
    // value unassigned, which would infer a latch.
    state_d     = state;
    dac_en_d    = dac_en_q;
    dac_value_d = dac_value_q;
    req_cmpt_d  = '0;            // completion is a single-cycle pulse
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef DAC_ARB_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
    dac_err_d   = dac_err_q;
`endif

    unique case (state)
      S_IDLE: begin
        if (winner_vld) begin
          dac_value_d = win_value;
          dac_en_d    = 1'b1;
          grant_d     = winner;
          state_d     = S_WAIT;
`ifdef DAC_ARB_TIMEOUT_EN
          to_cnt_d    = '0;
`endif
        end
      end

      S_WAIT: begin
        // The transfer is atomic: a requester withdrawing here only loses
        // its completion pulse, the driver is never cut short.
        if (bus.dac_cmpt) begin
          dac_en_d = 1'b0;
          rr_ptr_d = next_ptr;
          if (grant_req) begin
            req_cmpt_d = grant_onehot;
            state_d    = S_REL;
          end else begin
            state_d    = S_IDLE;
          end
        end
`ifdef DAC_ARB_TIMEOUT_EN
        else if (to_hit) begin
          // Give up on the driver; the requester stays pending.
          dac_en_d  = 1'b0;
          dac_err_d = 1'b1;
          rr_ptr_d  = next_ptr;
          state_d   = S_IDLE;
        end else begin
          to_cnt_d  = to_cnt_q + 1'b1;
        end
`endif
      end

      S_REL: begin
        // Hold off until the served requester lowers its enable so a stale
        // level is never mistaken for a new request.
        if (!grant_req) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.dac_en    = dac_en_q;
  assign bus.dac_value = dac_value_q;
  assign bus.req_cmpt  = req_cmpt_q;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = (state != S_IDLE);
`ifdef DAC_ARB_TIMEOUT_EN
  assign bus.dac_err   = dac_err_q;
`else
  assign bus.dac_err   = 1'b0;
`endif

endmodule

// File: tb/tb_tc_pl_cap_gain_dac_arb.sv
// ---------------------------------------------------------------------------
// tb_tc_pl_cap_gain_dac_arb
//
// Bench for the gain-DAC round-robin arbiter. A transaction-level reference
// model (pending set, round-robin pointer, outstanding transfer, release
// wait) predicts every output after each clock edge; directed scenarios
// exercise the documented corner cases and a randomized phase with
// requesters, withdrawals, value changes and stray driver pulses follows.
// Build with +define+DAC_ARB_TIMEOUT_EN to cover the watchdog.
// ---------------------------------------------------------------------------
module tb_tc_pl_cap_gain_dac_arb;
  localparam int CHN_NUM     = 4;
  localparam int DAC_W       = 24;
  localparam int ID_W        = 2;
  localparam int TIMEOUT_CYC = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tc_pl_cap_gain_dac_arb_if #(.CHN_NUM(CHN_NUM), .DAC_W(DAC_W), .ID_W(ID_W)) bus ();

  tc_pl_cap_gain_dac_arb #(
    .CHN_NUM(CHN_NUM), .DAC_W(DAC_W), .ID_W(ID_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (updated on each rising edge) --------
  int               m_ptr, m_grant, m_cnt;
  bit               m_inflight, m_hold, m_err, m_en;
  logic [DAC_W-1:0] m_value;
  logic [CHN_NUM-1:0] m_cmpt;

  always @(posedge clk) begin
    if (rst) begin
      m_ptr = 0; m_grant = 0; m_cnt = 0;
      m_inflight = 0; m_hold = 0; m_err = 0; m_en = 0;
      m_value = '0; m_cmpt = '0;
    end else begin
      m_cmpt = '0;
      if (m_inflight) begin
        if (bus.dac_cmpt) begin
          m_inflight = 0; m_en = 0;
          m_ptr = (m_grant + 1) % CHN_NUM;
          if (bus.req_en[m_grant]) begin
            m_cmpt[m_grant] = 1'b1;
            m_hold = 1;
          end
        end
`ifdef DAC_ARB_TIMEOUT_EN
        else if (m_cnt + 1 >= TIMEOUT_CYC) begin
          m_inflight = 0; m_en = 0; m_err = 1;
          m_ptr = (m_grant + 1) % CHN_NUM;
        end else begin
          m_cnt++;
        end
`endif
      end else if (m_hold) begin
        if (!bus.req_en[m_grant]) m_hold = 0;
      end else if (bus.req_en != '0) begin
        for (int k = 0; k < CHN_NUM; k++) begin
          if (bus.req_en[(m_ptr + k) % CHN_NUM]) begin
            m_grant = (m_ptr + k) % CHN_NUM;
            break;
          end
        end
        m_value = bus.req_value[m_grant*DAC_W +: DAC_W];
        m_inflight = 1; m_en = 1; m_cnt = 0;
      end
    end
  end

  // ---------------- stimulus agents --------------------------------------
  bit  auto_rel, drv_auto, rand_mode;
  int  reassert_gap, drv_delay, drv_cnt;
  int  reassert_cnt [CHN_NUM];
  bit  prev_en;
  logic [ID_W-1:0] grant_log [$];

  // One clock: compare outputs against the model at the falling edge, then
  // update the requester and driver inputs for the next rising edge.
  task automatic cycle();
    bit just_rel;
    @(negedge clk);
    check("dac_en",    bus.dac_en,    m_en);
    check("dac_value", bus.dac_value, m_value);
    check("grant_id",  bus.grant_id,  m_grant);
    check("req_cmpt",  bus.req_cmpt,  m_cmpt);
    check("busy",      bus.busy,      m_inflight | m_hold);
    check("dac_err",   bus.dac_err,   m_err);
    check("cmpt_onehot", ($countones(bus.req_cmpt) <= 1), 1);
    if (bus.dac_en && !prev_en) grant_log.push_back(bus.grant_id);
    prev_en = bus.dac_en;
    bus.dac_cmpt = 1'b0;
    for (int i = 0; i < CHN_NUM; i++) begin
      just_rel = 0;
      if (auto_rel && bus.req_cmpt[i] && bus.req_en[i]) begin
        bus.req_en[i] = 1'b0;
        just_rel = 1;
        if (reassert_gap > 0) reassert_cnt[i] = reassert_gap;
      end else if (reassert_cnt[i] > 0) begin
        reassert_cnt[i]--;
        if (reassert_cnt[i] == 0) bus.req_en[i] = 1'b1;
      end
      if (rand_mode && !just_rel) begin
        if (!bus.req_en[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            bus.req_en[i] = 1'b1;
            bus.req_value[i*DAC_W +: DAC_W] = DAC_W'($urandom);
          end
        end else if ($urandom_range(0, 63) == 0) begin
          bus.req_en[i] = 1'b0;
        end else if ($urandom_range(0, 7) == 0) begin
          bus.req_value[i*DAC_W +: DAC_W] = DAC_W'($urandom);
        end
      end
    end
    if (drv_auto) begin
      if (bus.dac_en) begin
        if (drv_cnt >= drv_delay) begin
          bus.dac_cmpt = 1'b1;
          drv_cnt = 0;
          if (rand_mode) drv_delay = $urandom_range(1, 20);
        end else begin
          drv_cnt++;
        end
      end else begin
        drv_cnt = 0;
        if (rand_mode && $urandom_range(0, 49) == 0) bus.dac_cmpt = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    auto_rel = 0; drv_auto = 0; rand_mode = 0;
    reassert_gap = 0; drv_delay = 4; drv_cnt = 0;
    for (int i = 0; i < CHN_NUM; i++) reassert_cnt[i] = 0;
    rst = 1'b1;
    bus.req_en = '0;
    bus.dac_cmpt = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    grant_log.delete();
    prev_en = 0;
  endtask

  task automatic wait_grants(input string tag, input int n, input int budget);
    int c = 0;
    while (grant_log.size() < n && c < budget) begin
      cycle();
      c++;
    end
    check(tag, (grant_log.size() >= n), 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int c = 0;
    while (bus.busy && c < budget) begin
      cycle();
      c++;
    end
    check(tag, bus.busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.req_en = '0;
    bus.req_value = '0;
    bus.dac_cmpt = 1'b0;
    prev_en = 0;

    // ---- reset state and single request ----
    do_reset();
    check("rst_dac_en", bus.dac_en, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_value", bus.dac_value, 0);
    bus.req_value[0 +: DAC_W] = 24'h60_1234;
    bus.req_en[0] = 1'b1;
    cycle();
    check("single_en", bus.dac_en, 1);
    check("single_val", bus.dac_value, 24'h60_1234);
    repeat (29) cycle();
    bus.dac_cmpt = 1'b1;
    cycle();
    check("single_cmpt", bus.req_cmpt, 4'b0001);
    cycle();
    check("single_pulse_w", bus.req_cmpt, 4'b0000);
    check("single_rel_busy", bus.busy, 1);
    bus.req_en[0] = 1'b0;
    cycle();
    check("single_idle", bus.busy, 0);

    // ---- contention: all four pending, two rounds of strict order ----
    do_reset();
    for (int i = 0; i < CHN_NUM; i++) bus.req_value[i*DAC_W +: DAC_W] = DAC_W'($urandom);
    bus.req_en = 4'b1111;
    auto_rel = 1; reassert_gap = 2; drv_auto = 1; drv_delay = 4;
    wait_grants("rr_budget", 8, 400);
    for (int i = 0; i < grant_log.size() && i < 8; i++)
      check("rr_order", grant_log[i], i % CHN_NUM);
    reassert_gap = 0;

    // ---- pointer fairness: serve ch2, then 0101 -> ch0 before ch2 ----
    do_reset();
    auto_rel = 1; drv_auto = 1; drv_delay = 3;
    bus.req_en = 4'b0100;
    wait_grants("ptr_first", 1, 50);
    wait_idle("ptr_idle", 50);
    bus.req_en = 4'b0101;
    wait_grants("ptr_budget", 3, 100);
    if (grant_log.size() >= 3) begin
      check("ptr_g0", grant_log[0], 2);
      check("ptr_g1", grant_log[1], 0);
      check("ptr_g2", grant_log[2], 2);
    end

    // ---- abort: ch1 withdraws mid-transfer ----
    do_reset();
    bus.req_value[1*DAC_W +: DAC_W] = 24'hA5_0001;
    bus.req_value[3*DAC_W +: DAC_W] = 24'h3C_0003;
    bus.req_en = 4'b0010;
    cycle();
    check("abort_grant", bus.grant_id, 1);
    repeat (5) cycle();
    bus.req_en[1] = 1'b0;
    bus.req_en[3] = 1'b1;
    repeat (4) begin
      cycle();
      check("abort_hold", bus.dac_en, 1);
    end
    bus.dac_cmpt = 1'b1;
    cycle();
    check("abort_no_cmpt", bus.req_cmpt, 0);
    check("abort_en_drop", bus.dac_en, 0);
    cycle();
    check("abort_next_id", bus.grant_id, 3);
    check("abort_next_val", bus.dac_value, 24'h3C_0003);

    // ---- reset mid-transfer (ch3 in flight) ----
    rst = 1'b1;
    bus.req_en = '0;
    cycle();
    check("mid_rst_en", bus.dac_en, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_id", bus.grant_id, 0);
    rst = 1'b0;
    bus.dac_cmpt = 1'b1;
    cycle();
    check("stray_cmpt", bus.req_cmpt, 0);
    check("stray_busy", bus.busy, 0);

    // ---- watchdog ----
    do_reset();
`ifdef DAC_ARB_TIMEOUT_EN
    begin
      int hi = 0;
      int guard = 0;
      bus.req_en = 4'b0011;
      do begin
        cycle();
        if (bus.dac_en) hi++;
        guard++;
      end while ((hi == 0 || bus.dac_en) && guard < 100);
      check("to_len", hi, TIMEOUT_CYC);
      check("to_err", bus.dac_err, 1);
      cycle();
      check("to_next_id", bus.grant_id, 1);
      check("to_next_en", bus.dac_en, 1);
      repeat (3) cycle();
      check("to_err_sticky", bus.dac_err, 1);
    end
`else
    bus.req_en = 4'b0001;
    repeat (40) cycle();
    check("no_to_en", bus.dac_en, 1);
    check("no_to_err", bus.dac_err, 0);
`endif

    // ---- randomized traffic ----
    do_reset();
    rand_mode = 1; auto_rel = 1; drv_auto = 1; drv_delay = 5;
    repeat (3000) cycle();
    check("rand_progress", (grant_log.size() > 50), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
